// File: rtl/instr_encoder_loader_pkg.sv
// Shared picoMIPS instruction definitions: opcodes, field layout and entry-field encodings.
// Both the decoder and the encoder loader import this so the word layout is defined once.
package instr_encoder_loader_pkg;

  localparam int OPC_W = 3;
  localparam int REG_W = 3;
  localparam int IMM_W = 8;

  localparam int IMM_LSB = 0;
  localparam int RS_LSB  = IMM_LSB + IMM_W;
  localparam int RD_LSB  = RS_LSB + REG_W;
  localparam int OPC_LSB = RD_LSB + REG_W;
  localparam int INSTR_W = OPC_LSB + OPC_W;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_MULI  = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_HOLD  = 3'b101;

  localparam logic [1:0] FS_OPC   = 2'd0;
  localparam logic [1:0] FS_REGS  = 2'd1;
  localparam logic [1:0] FS_IMM   = 2'd2;
  localparam logic [1:0] FS_WRITE = 2'd3;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_HOLD;
  endfunction

  function automatic logic op_no_operands(input logic [2:0] op);
    return (op == OP_NOP) || (op == OP_HOLD);
  endfunction

  function automatic logic op_has_imm(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_MULI);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational instruction packer: fields in, word out, with fields unused by the
// opcode forced to zero so the stored program is canonical.
module instr_pack
  import instr_encoder_loader_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int REGW = 3,
  parameter int IMMW = 8
) (
  input  logic [OPW-1:0]            opc,
  input  logic [REGW-1:0]           rd,
  input  logic [REGW-1:0]           rs,
  input  logic [IMMW-1:0]           imm,
  output logic [OPW+2*REGW+IMMW-1:0] word
);

  logic [REGW-1:0] rd_z;
  logic [REGW-1:0] rs_z;
  logic [IMMW-1:0] imm_z;

  always_comb begin
    rd_z  = rd;
    rs_z  = rs;
    imm_z = imm;
    if (opc == OPW'(OP_NOP) || opc == OPW'(OP_HOLD)) begin
      rd_z  = '0;
      rs_z  = '0;
      imm_z = '0;
    end else if (opc == OPW'(OP_ADD) || opc == OPW'(OP_INPUT)) begin
      imm_z = '0;
    end
    if (opc == OPW'(OP_INPUT)) rs_z = '0;
  end

  assign word = {opc, rd_z, rs_z, imm_z};

endmodule

// File: rtl/instr_encoder_loader.sv
// Switch-driven instruction entry FSM: collects opcode/regs/imm fields on strobe
// pulses and writes packed words into program RAM while load mode is held.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int REGW = 3,
  parameter int IMMW = 8,
  parameter int AW   = 5,
  parameter int WRAP = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_en,
  input  logic [7:0]                  SW,
  input  logic                        strobe,
  output logic                        prog_we,
  output logic [AW-1:0]               prog_addr,
  output logic [OPW+2*REGW+IMMW-1:0]  prog_wdata,
  output logic [1:0]                  field_sel,
  output logic [AW:0]                 count,
  output logic                        full,
  output logic                        err
);

  typedef enum logic [2:0] {S_IDLE, S_OPC, S_REGS, S_IMM, S_WRITE} state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [AW:0]   CNT_MAX  = {1'b1, {AW{1'b0}}};

  state_t          state;
  logic [OPW-1:0]  opc_q, nx_opc;
  logic [REGW-1:0] rd_q, rs_q, nx_rd, nx_rs;
  logic [IMMW-1:0] imm_q, nx_imm;
  logic [OPW+2*REGW+IMMW-1:0] word_nx;
  logic            fire;

  // Fields as they will be after this edge, so the word registers in the same cycle.
  always_comb begin
    nx_opc = opc_q;
    nx_rd  = rd_q;
    nx_rs  = rs_q;
    nx_imm = imm_q;
    case (state)
      S_OPC: begin
        nx_opc = SW[OPW-1:0];
        nx_rd  = '0;
        nx_rs  = '0;
        nx_imm = '0;
      end
      S_REGS: begin
        nx_rd  = SW[2*REGW-1:REGW];
        nx_rs  = SW[REGW-1:0];
        nx_imm = '0;
      end
      S_IMM:   nx_imm = SW[IMMW-1:0];
      default: ;
    endcase
  end

  always_comb begin
    fire = 1'b0;
    if (load_en && strobe) begin
      case (state)
        S_OPC:   fire = !full && op_legal(3'(SW[OPW-1:0])) && op_no_operands(3'(SW[OPW-1:0]));
        S_REGS:  fire = !op_has_imm(3'(opc_q));
        S_IMM:   fire = 1'b1;
        default: fire = 1'b0;
      endcase
    end
  end

  instr_pack #(.OPW(OPW), .REGW(REGW), .IMMW(IMMW)) u_pack (
    .opc  (nx_opc),
    .rd   (nx_rd),
    .rs   (nx_rs),
    .imm  (nx_imm),
    .word (word_nx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      opc_q      <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      imm_q      <= '0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      field_sel  <= FS_OPC;
      count      <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      if (!load_en) begin
        state     <= S_IDLE;
        field_sel <= FS_OPC;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_OPC;
            field_sel <= FS_OPC;
            prog_addr <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
          end
          S_OPC: if (strobe && !full) begin
            opc_q <= nx_opc;
            rd_q  <= '0;
            rs_q  <= '0;
            imm_q <= '0;
            if (!op_legal(3'(SW[OPW-1:0]))) begin
              err <= 1'b1;
            end else begin
              err <= 1'b0;
              if (op_no_operands(3'(SW[OPW-1:0]))) begin
                state     <= S_WRITE;
                field_sel <= FS_WRITE;
              end else begin
                state     <= S_REGS;
                field_sel <= FS_REGS;
              end
            end
          end
          S_REGS: if (strobe) begin
            rd_q  <= nx_rd;
            rs_q  <= nx_rs;
            imm_q <= '0;
            if (op_has_imm(3'(opc_q))) begin
              state     <= S_IMM;
              field_sel <= FS_IMM;
            end else begin
              state     <= S_WRITE;
              field_sel <= FS_WRITE;
            end
          end
          S_IMM: if (strobe) begin
            imm_q     <= nx_imm;
            state     <= S_WRITE;
            field_sel <= FS_WRITE;
          end
          S_WRITE: begin
            state     <= S_OPC;
            field_sel <= FS_OPC;
            if (count != CNT_MAX) count <= count + 1'b1;
            if (prog_addr == ADDR_MAX) begin
              if (WRAP != 0) prog_addr <= '0;
              else           full      <= 1'b1;
            end else begin
              prog_addr <= prog_addr + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
        if (fire) begin
          prog_we    <= 1'b1;
          prog_wdata <= word_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (AW=2, WRAP=0); writes are checked
// against a scoreboard of expected {addr, word} pushed when the final strobe is driven.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [7:0]  SW;
  logic        strobe;
  logic        prog_we;
  logic [1:0]  prog_addr;
  logic [16:0] prog_wdata;
  logic [1:0]  field_sel;
  logic [2:0]  count;
  logic        full;
  logic        err;

  int tests  = 0;
  int failed = 0;
  logic [18:0] sb[$];

  instr_encoder_loader #(.AW(2), .WRAP(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .SW         (SW),
    .strobe     (strobe),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .field_sel  (field_sel),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] val);
    @(posedge clk); #1;
    SW = val;
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic expect_wr(input logic [1:0] a, input logic [16:0] d);
    sb.push_back({a, d});
  endtask

  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      logic [18:0] e;
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $error("FAIL unexpected_write: got addr %0h data %05h expected no write", prog_addr, prog_wdata);
      end else begin
        e = sb.pop_front();
        assert ({prog_addr, prog_wdata} === e) else begin
          failed++;
          $error("FAIL write: got addr %0h data %05h expected addr %0h data %05h",
                 prog_addr, prog_wdata, e[18:17], e[16:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_en = 1'b0; SW = '0; strobe = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", prog_we, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_wdata", prog_wdata, 0);
    chk("rst_fsel", field_sel, 0);
    chk("rst_count", count, 0);
    chk("rst_full_err", {full, err}, 0);
    reset = 1'b0;
    load_en = 1'b1;
    repeat (2) @(negedge clk);

    // ADDI r1, r2, 0x7F
    expect_wr(2'd0, 17'h08A7F);
    pulse(8'h02);
    @(negedge clk); chk("addi_fsel_regs", field_sel, 1);
    pulse(8'h0A);
    @(negedge clk); chk("addi_fsel_imm", field_sel, 2);
    pulse(8'h7F);
    chk("addi_we_latency", prog_we, 1);
    @(posedge clk); @(negedge clk);
    chk("addi_count", count, 1);
    chk("addi_next_addr", prog_addr, 1);

    // HOLD: one strobe writes
    expect_wr(2'd1, 17'h14000);
    pulse(8'h05);
    @(negedge clk); chk("hold_fsel_write", field_sel, 3);
    @(negedge clk); chk("hold_fsel_back", field_sel, 0);

    // illegal opcode, then ADD r5, r3
    pulse(8'h07);
    @(negedge clk);
    chk("illegal_err", err, 1);
    chk("illegal_fsel", field_sel, 0);
    pulse(8'h01);
    @(negedge clk);
    chk("valid_clears_err", err, 0);
    chk("add_fsel_regs", field_sel, 1);
    expect_wr(2'd2, 17'h06B00);
    pulse(8'h2B);

    // INPUT r7 with rs forced to zero, fills the last location
    expect_wr(2'd3, 17'h13800);
    pulse(8'h04);
    pulse(8'h3F);
    repeat (2) @(negedge clk);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    pulse(8'h00);
    repeat (2) @(negedge clk);
    chk("full_ignores_count", count, 4);

    // reload clears
    @(posedge clk); #1 load_en = 1'b0;
    @(posedge clk); #1 load_en = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reload_full", full, 0);
    chk("reload_count", count, 0);
    chk("reload_addr", prog_addr, 0);

    // four NOPs fill AW=2 memory
    for (int i = 0; i < 4; i++) begin
      expect_wr(2'(i), 17'h00000);
      pulse(8'h00);
    end
    repeat (2) @(negedge clk);
    chk("nop_full", full, 1);
    chk("nop_count", count, 4);
    pulse(8'h00);
    repeat (2) @(negedge clk);
    chk("nop_5th_fsel", field_sel, 0);
    @(posedge clk); #1 load_en = 1'b0;
    @(posedge clk); #1 load_en = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("nop_reload", {full, count, prog_addr}, 0);

    // abort by dropping load_en before imm
    pulse(8'h02);
    pulse(8'h0A);
    #1 load_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_fsel", field_sel, 0);
    chk("abort_count", count, 0);
    @(posedge clk); #1 load_en = 1'b1;
    repeat (2) @(negedge clk);

    // reset during the write cycle drops prog_we immediately
    pulse(8'h02);
    pulse(8'h0A);
    pulse(8'h7F);
    chk("pre_reset_we", prog_we, 1);
    reset = 1'b1;
    #1;
    chk("async_we", prog_we, 0);
    chk("async_wdata", prog_wdata, 0);
    chk("async_fsel", field_sel, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);

    // strobe held 3 cycles: MULI r0, r3, 0x03
    expect_wr(2'd0, 17'h0C303);
    @(posedge clk); #1;
    SW = 8'h03;
    strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 strobe = 1'b0;
    chk("held_we", prog_we, 1);
    repeat (3) @(negedge clk);
    chk("held_count", count, 1);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential front-end that encodes picoMIPS instructions entered from the board switches and writes them into program memory. It performs the inverse of the instruction decoder: fields in, packed instruction word out.
- Sits between the switch/button inputs and the program RAM write port. It runs only while the CPU is held in load mode.

Parameters:
- OPW, 3, opcode field width
- REGW, 3, register index field width
- IMMW, 8, immediate field width
- AW, 5, program memory address width (depth 2**AW)
- WRAP, 0, 1 = address wraps to 0 after the last location; 0 = stop and assert full

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load_en  input  1  load mode; 0 forces the FSM to IDLE on the next edge
- SW  input  8  field entry data from the switches
- strobe  input  1  one-cycle "enter" pulse, already debounced and synchronous
- prog_we  output  1  program RAM write enable, one cycle per instruction
- prog_addr  output  AW  program RAM write address
- prog_wdata  output  OPW+2*REGW+IMMW  encoded instruction
- field_sel  output  2  field currently expected: 0=opcode, 1=regs, 2=imm, 3=write
- count  output  AW+1  number of instructions written since reset or clear
- full  output  1  memory full (WRAP=0 only)
- err  output  1  sticky flag, set by an illegal opcode; cleared by the next valid opcode entry

Behaviour:
- Word format: [16:14] opcode, [13:11] rd, [10:8] rs, [7:0] imm (default widths).
- Opcode values come from the shared opcode definitions: NOP=000, ADD=001, ADDI=010, MULI=011, INPUT=100, HOLD=101. Codes 110 and 111 are illegal.
- Reset values: all outputs 0, FSM in IDLE, address 0, internal field registers 0.
- FSM states: IDLE, OPC, REGS, IMM, WRITE.
- IDLE -> OPC when load_en=1.
- OPC, on strobe: latch SW[2:0] as the opcode.
  - Illegal opcode: set err, stay in OPC.
  - NOP or HOLD: clear rd, rs and imm, go to WRITE.
  - Any other legal opcode: clear err, go to REGS.
- REGS, on strobe: rd=SW[5:3], rs=SW[2:0].
  - ADDI or MULI: go to IMM.
  - ADD or INPUT: imm=0, go to WRITE.
  - For INPUT, rs is forced to 0.
- IMM, on strobe: imm=SW[7:0], go to WRITE.
- WRITE lasts exactly one cycle:
  - prog_we=1 with the registered prog_addr and prog_wdata.
  - Next edge: address+1 and count+1; return to OPC.
  - Latency from the final strobe to prog_we is 1 cycle.
  - prog_wdata is held stable until the next WRITE.
- Strobe handling: a strobe arriving in WRITE or IDLE is ignored, not queued. Holding strobe high for more than one cycle advances one field per cycle; a test bench must pulse it.
- Boundary at address 2**AW-1:
  - WRAP=1: address returns to 0 and count saturates at 2**AW.
  - WRAP=0: full=1 after the write; FSM goes to OPC but further strobes are ignored until load_en falls.
- load_en falling in any state: IDLE on the next edge; the partially entered instruction is discarded and no write occurs.
- load_en rising again from IDLE: address, count, full and err all cleared (new program load).
- Reset asserted mid-operation: immediate return to the reset values; a write in progress is aborted and prog_we drops asynchronously.

Decomposition:
- Opcode constants: reuse the shared opcode definitions (same file as the decoder uses).
- Add to the shared definitions: the field-offset constants and the field_sel encodings, so the decoder and the encoder cannot diverge.
- Declare the FSM state enum locally.
- One natural sub-module: instr_pack. It is purely combinational: opcode, rd, rs and imm in, word out, with the per-opcode field zeroing. The FSM and the address counter stay in the top module.

Test Plan:
- Reset, load_en=1, strobes SW=8'h02 (ADDI), 8'h0A (rd=1, rs=2), 8'h7F -> one cycle later prog_we=1, prog_addr=0, prog_wdata=17'h08A7F, count=1.
- Strobes SW=8'h05 (HOLD) -> write after a single strobe, prog_wdata=17'h14000, field_sel sequence 0 -> 3 -> 0.
- Strobe SW=8'h07 -> err=1, no prog_we, field_sel stays 0. Then SW=8'h01 -> err=0, field_sel=1.
- WRAP=0, AW=2: write 4 NOPs -> full=1, count=4; a 5th strobe produces no prog_we. Drop then raise load_en -> full=0, count=0, prog_addr=0.
- Enter ADDI and regs, then drop load_en before the imm strobe -> no write, IDLE. Repeat with reset asserted mid-entry -> all outputs 0 immediately.
- Strobe held high for 3 cycles from OPC with SW=8'h03 -> three fields consumed, write occurs on cycle 4.
